accumulate: RTL and testbench
=============================

# accumulate

Channel-accumulation stage placed directly upstream of the block-RAM write stage. It takes a stream of GROUP_SIZE-lane data groups, sums every `num_accum` consecutive groups lane by lane, and emits one summed group per window. Its IN side uses the codebase valid/avail handshake. Its OUT side drives the write stage's `data_in`/`valid_in` and obeys that stage's `avail_out`.

## Interface
- GROUP_SIZE, 4, lanes per group
- DATA_WIDTH, 8, bits per lane (input and output)
- LOG_MAX_ACCUM, 16, width of the accumulation-count field
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- configure  in  1  single-cycle configure strobe
- num_accum  in  LOG_MAX_ACCUM  groups per window, sampled on `configure`; 0 is treated as 1
- data_in  in  GROUP_SIZE*DATA_WIDTH  input group; lane i is bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- valid_in  in  1  input group valid
- avail_out  out  1  upstream may send
- data_out  out  GROUP_SIZE*DATA_WIDTH  accumulated group (registered)
- valid_out  out  1  one-cycle pulse per result (registered)
- avail_in  in  1  downstream can accept a result

## Operation
- **Input FIFO**
  - 4 slots, no fall-through.
  - A push occurs on every cycle with `valid_in`=1.
  - A push into a full FIFO is dropped; this is an upstream contract violation.
  - `avail_out` = (occupancy < 2), combinational from registered occupancy. Upstream may issue one more `valid_in` in the cycle after `avail_out` falls.
- **Registers**: `configured_r`, `num_accum_r`, `count_r` [LOG_MAX_ACCUM], `acc_r` [GROUP_SIZE*DATA_WIDTH].
- **Configure**
  - Sets `configured_r`=1 and loads `num_accum_r` (0 becomes 1).
  - Clears `count_r` and discards any partial sum.
  - Does not alter FIFO contents or the output registers.
- **Pop condition** (all must hold): `configured_r`=1, FIFO not empty, `configure`=0, and (`count_r` != `num_accum_r`-1 or `avail_in`=1). Only the last group of a window waits on `avail_in`.
- **Per-lane sum** on a pop: s = (`count_r`==0 ? 0 : `acc_r` lane) + FIFO head lane, unsigned, modulo 2^DATA_WIDTH (wrap, no saturation). Clipping belongs to the write stage.
- **Non-final pop** (`count_r` < `num_accum_r`-1): `acc_r` <= s, `count_r` <= `count_r`+1.
- **Final pop** (`count_r` == `num_accum_r`-1):
  - `data_out` <= s, `valid_out` <= 1.
  - `count_r` <= 0; `acc_r` is don't-care.
- **valid_out**: 0 on every cycle with no final pop. `data_out` holds its last value.
- **States**
  - UNCONF (`configured_r`=0): no pops.
  - ACCUM (`count_r` < `num_accum_r`-1).
  - LAST (`count_r` == `num_accum_r`-1).
  - ACCUM→LAST after the pop that makes `count_r` = `num_accum_r`-1.
  - LAST→ACCUM on a final pop. With `num_accum_r`=1 it stays in LAST.
  - Any state→ACCUM or LAST on `configure`, via `count_r`=0.

## Timing
- **Reset values**: `valid_out`=0, `data_out`=0, `avail_out`=1, FIFO empty, `configured_r`=0, `count_r`=0, `acc_r`=0, `num_accum_r`=1.
- **Reset** asserted mid-window discards FIFO contents and the partial sum. The next cycle behaves as post-reset.
- **Push-to-pop**: push at cycle t, earliest pop at t+1.
- **Latency**: final pop at t gives `valid_out`=1 at t+1.
  - Minimum input-to-output with `num_accum`=1: `valid_in` at t, `valid_out` at t+2.
- **Throughput**: one pop per cycle; one result per `num_accum` cycles when fed continuously and `avail_in`=1.
- **Simultaneous events**
  - `configure` and a would-be pop in the same cycle: configure wins; no pop occurs.
  - Push and pop in the same cycle: occupancy unchanged. Push into a full FIFO while popping is accepted.
  - `configure` in the cycle after a final pop: that result's `valid_out` pulse still occurs.
- **Back-pressure**: `avail_in` is sampled only at the final pop. When it is low, the FIFO fills and `avail_out` drops at occupancy 2.

## Test plan
- **Basic window**: reset; configure `num_accum`=3; send lanes {1,2,3,4}, {10,20,30,40}, {5,5,5,5} on consecutive cycles with `avail_in`=1 → one `valid_out` pulse carrying {16,27,38,49}, 2 cycles after the last push.
- **Wrap and pass-through**
  - `num_accum`=2, DATA_WIDTH=8; send {200,255,0,128} then {100,1,0,128} → {44,0,0,0}.
  - `num_accum`=0 → every input is emitted unchanged, one result per input, latency 2.
- **Back-pressure**: `num_accum`=1, `avail_in`=0, continuous `valid_in` while `avail_out`=1 → `avail_out` falls after 2 pushes; at most 3 groups are accepted; no `valid_out`. Raising `avail_in` → 3 results in order on consecutive cycles.
- **Reconfigure mid-window**: `num_accum`=4; send 2 groups of {7,7,7,7}; configure `num_accum`=2; send {1,1,1,1} and {2,2,2,2} → single result {3,3,3,3}; the partial sum of 14 never appears.
- **Reset mid-operation**: FIFO holding 3 groups and a partial sum; assert `rst` for 1 cycle → next cycle `valid_out`=0, `data_out`=0, `avail_out`=1. Input with no `configure` afterwards → no pops and no output.

Source files
------------

// File: rtl/accumulate.sv
// accumulate
// ----------
// Channel-accumulation stage that sits in front of the block-RAM write stage.
// It sums every num_accum consecutive GROUP_SIZE-lane groups lane by lane and
// emits one summed group per window. Lane sums wrap modulo 2^DATA_WIDTH. The
// write stage downstream does any clipping.
//
// Ports
//   clk        clock; all logic on posedge
//   rst        synchronous, active-high reset
//   configure  single-cycle strobe; loads num_accum and restarts the window
//   num_accum  groups per window (0 is treated as 1)
//   data_in    input group; lane i is bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   valid_in   input group valid
//   avail_out  upstream may send
//   data_out   accumulated group (registered)
//   valid_out  one-cycle pulse per result (registered)
//   avail_in   downstream can accept a result
//   state_dbg  current FSM state, for observation only
//
// Handshake
//   IN:  each cycle with valid_in=1 pushes data_in into a 4-deep FIFO.
//        avail_out is (occupancy < 2). Upstream reacts one cycle late, so it
//        may push once more after avail_out falls. The two spare slots absorb
//        that extra push. A push into a full FIFO is dropped unless a pop
//        happens in the same cycle.
//   OUT: the final pop of a window fires only when avail_in=1. It produces a
//        one-cycle valid_out pulse on the next cycle. Non-final pops ignore
//        avail_in.
module accumulate #(
  parameter int GROUP_SIZE    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int LOG_MAX_ACCUM = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             configure,
  input  logic [LOG_MAX_ACCUM-1:0]         num_accum,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
  input  logic                             valid_in,
  output logic                             avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  input  logic                             avail_in,
  output logic [1:0]                       state_dbg
);

  localparam int W = GROUP_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_UNCONF = 2'd0,  // no num_accum loaded yet; nothing is popped
    ST_ACCUM  = 2'd1,  // count_r < num_accum_r-1
    ST_LAST   = 2'd2   // count_r == num_accum_r-1; the next pop completes a window
  } state_t;

  state_t                   state_r, state_next;
  logic [LOG_MAX_ACCUM-1:0] num_accum_r;
  logic [LOG_MAX_ACCUM-1:0] count_r;
  logic [W-1:0]             acc_r;

  // Input FIFO
  logic [W-1:0] fifo_mem [4];
  logic [1:0]   wr_ptr, rd_ptr;
  logic [2:0]   occ;
  logic         fifo_empty, fifo_full;
  logic         push, pop;
  logic [W-1:0] head;

  logic [LOG_MAX_ACCUM-1:0] num_cfg;
  logic [LOG_MAX_ACCUM-1:0] count_inc;
  logic                     is_final;
  logic [W-1:0]             sum;

  assign fifo_empty = (occ == 3'd0);
  assign fifo_full  = (occ == 3'd4);
  assign avail_out  = (occ < 3'd2);
  assign head       = fifo_mem[rd_ptr];
  assign state_dbg  = state_r;

  assign num_cfg   = (num_accum == '0) ? LOG_MAX_ACCUM'(1) : num_accum;
  assign count_inc = count_r + LOG_MAX_ACCUM'(1);
  assign is_final  = (state_r == ST_LAST);

  // configure has priority over a pop in the same cycle.
  // Only the last group of a window waits on avail_in.
  assign pop  = (state_r != ST_UNCONF) && !fifo_empty && !configure &&
                (!is_final || avail_in);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign push = valid_in && (!fifo_full || pop);

  // Per-lane wrapping sum. The first group of a window starts from zero, so
  // acc_r does not need clearing between windows.
  always_comb begin
    sum = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      sum[i*DATA_WIDTH +: DATA_WIDTH] =
        ((count_r == '0) ? '0 : acc_r[i*DATA_WIDTH +: DATA_WIDTH]) +
        head[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FSM next state
  always_comb begin
    state_next = state_r;
    if (configure) begin
      state_next = (num_cfg == LOG_MAX_ACCUM'(1)) ? ST_LAST : ST_ACCUM;
    end else if (pop) begin
      case (state_r)
        ST_LAST:  state_next = (num_accum_r == LOG_MAX_ACCUM'(1)) ? ST_LAST : ST_ACCUM;
        ST_ACCUM: state_next = (count_inc == num_accum_r - LOG_MAX_ACCUM'(1)) ? ST_LAST : ST_ACCUM;
        default:  state_next = state_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_UNCONF;
    else     state_r <= state_next;
  end

  // FIFO storage needs no reset. Only the pointers and occupancy define contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Window datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      num_accum_r <= LOG_MAX_ACCUM'(1);
      count_r     <= '0;
      acc_r       <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (configure) begin
        // Restart the window. data_out and any pending valid_out pulse are untouched.
        num_accum_r <= num_cfg;
        count_r     <= '0;
        acc_r       <= '0;
      end else if (pop) begin
        if (is_final) begin
          data_out  <= sum;
          valid_out <= 1'b1;
          count_r   <= '0;
        end else begin
          acc_r   <= sum;
          count_r <= count_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_accumulate.sv
// Directed self-checking bench for accumulate.
module tb_accumulate;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        configure = 1'b0;
  logic [15:0] num_accum = '0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        avail_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        avail_in = 1'b1;
  logic [1:0]  state_dbg;

  accumulate dut (
    .clk       (clk),
    .rst       (rst),
    .configure (configure),
    .num_accum (num_accum),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .avail_out (avail_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .avail_in  (avail_in),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int out_count = 0;
  int last_out_cyc = -1;
  int last_send_cyc = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] grp(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Scoreboard: every valid_out pulse must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      out_count++;
      last_out_cyc = cyc;
      if (exp_q.size() == 0) check("spurious_valid_out", data_out, 32'hxxxx_xxxx);
      else                   check("data_out", data_out, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in  = 1'b0;
      configure = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] g);
    @(posedge clk); #1;
    configure     = 1'b0;
    valid_in      = 1'b1;
    data_in       = g;
    last_send_cyc = cyc;
  endtask

  task automatic do_config(input int n);
    @(posedge clk); #1;
    configure = 1'b1;
    num_accum = 16'(n);
    valid_in  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    valid_in  = 1'b0;
    configure = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int raise_cyc;

    // Reset state
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_valid_out", valid_out, 0);
    check("reset_data_out", data_out, 0);
    check("reset_avail_out", avail_out, 1);

    // Basic window of 3
    do_config(3);
    exp_q.push_back(grp(16, 27, 38, 49));
    base = out_count;
    send(grp(1, 2, 3, 4));
    send(grp(10, 20, 30, 40));
    send(grp(5, 5, 5, 5));
    drive_idle(4);
    check("basic_count", out_count - base, 1);
    check("basic_latency", last_out_cyc - last_send_cyc, 2);

    // Lane wrap, window of 2
    do_config(2);
    exp_q.push_back(grp(44, 0, 0, 0));
    base = out_count;
    send(grp(200, 255, 0, 128));
    send(grp(100, 1, 0, 128));
    drive_idle(4);
    check("wrap_count", out_count - base, 1);

    // num_accum=0 passes every group through
    do_config(0);
    exp_q.push_back(grp(9, 8, 7, 6));
    exp_q.push_back(grp(255, 0, 1, 128));
    exp_q.push_back(grp(33, 44, 55, 66));
    base = out_count;
    send(grp(9, 8, 7, 6));
    send(grp(255, 0, 1, 128));
    send(grp(33, 44, 55, 66));
    drive_idle(4);
    check("pass_count", out_count - base, 3);
    check("pass_latency", last_out_cyc - last_send_cyc, 2);

    // Back-pressure: send while avail_out=1, plus one late group
    avail_in = 1'b0;
    do_config(1);
    base = out_count;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      configure = 1'b0;
      if (!avail_out) break;
      valid_in = 1'b1;
      data_in  = grp(i + 1, i + 2, i + 3, i + 4);
      exp_q.push_back(grp(i + 1, i + 2, i + 3, i + 4));
      n++;
    end
    check("bp_pushes_before_avail_low", n, 2);
    valid_in = 1'b1;
    data_in  = grp(50, 60, 70, 80);
    exp_q.push_back(grp(50, 60, 70, 80));
    drive_idle(4);
    check("bp_avail_out_low", avail_out, 0);
    check("bp_no_output", out_count - base, 0);
    @(posedge clk); #1;
    avail_in  = 1'b1;
    raise_cyc = cyc;
    drive_idle(6);
    check("bp_count", out_count - base, 3);
    check("bp_last_out_cycle", last_out_cyc - raise_cyc, 3);
    check("bp_avail_out_high", avail_out, 1);

    // Reconfigure mid-window discards the partial sum
    do_config(4);
    base = out_count;
    send(grp(7, 7, 7, 7));
    send(grp(7, 7, 7, 7));
    drive_idle(2);
    do_config(2);
    exp_q.push_back(grp(3, 3, 3, 3));
    send(grp(1, 1, 1, 1));
    send(grp(2, 2, 2, 2));
    drive_idle(4);
    check("reconf_count", out_count - base, 1);

    // Reset mid-operation: partial sum plus queued groups
    avail_in = 1'b0;
    do_config(3);
    send(grp(1, 1, 1, 1));
    send(grp(2, 2, 2, 2));
    send(grp(3, 3, 3, 3));
    send(grp(4, 4, 4, 4));
    send(grp(5, 5, 5, 5));
    drive_idle(1);
    check("pre_reset_avail_out", avail_out, 0);
    base = out_count;
    do_reset();
    check("midrst_valid_out", valid_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_avail_out", avail_out, 1);
    avail_in = 1'b1;
    send(grp(11, 12, 13, 14));
    send(grp(15, 16, 17, 18));
    drive_idle(4);
    check("unconf_no_output", out_count - base, 0);
    check("unconf_no_pop", avail_out, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
